// File: rtl/frame_plotter_pkg.sv
// frame_plotter_pkg
//   Shared constants for the frame plotter slice: bitmap geometry, the
//   FSM state encoding, the pixel-port widths and the default colours.
//   Contents:
//     GRID_COLS/GRID_ROWS/NUM_CELLS   bitmap geometry (16 x 32 cells)
//     X_W/Y_W/COLOUR_W                vga_adapter pixel-port widths
//     ST_IDLE/ST_SCAN/ST_DONE         FSM encoding
//     DEFAULT_FG/DEFAULT_BG           default cell colours
//     pick_colour()                   maps a cell bit to its colour
package frame_plotter_pkg;

  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 32;
  localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [COLOUR_W-1:0] DEFAULT_FG = 3'b000;
  localparam logic [COLOUR_W-1:0] DEFAULT_BG = 3'b001;

  function automatic logic [COLOUR_W-1:0] pick_colour(
    input logic                bit_val,
    input logic [COLOUR_W-1:0] fg,
    input logic [COLOUR_W-1:0] bg
  );
    return bit_val ? fg : bg;
  endfunction

endpackage

// File: rtl/frame_plotter_if.sv
// frame_plotter_if
//   Pixel-write port between the frame plotter and the vga_adapter.
//   Signals:
//     x       pixel column (0..159)
//     y       pixel row (0..119)
//     colour  pixel colour
//     plot    write strobe, one pixel per high cycle
//   Modports: master (plotter side, drives), slave (vga_adapter side).
interface frame_plotter_if;
  import frame_plotter_pkg::*;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

  modport master (output x, output y, output colour, output plot);
  modport slave  (input  x, input  y, input  colour, input  plot);

endinterface

// File: rtl/frame_plotter_cell_pixel_counter.sv
// cell_pixel_counter
//   Walks the CELL x CELL pixels of one bitmap cell: sx runs fastest,
//   sy steps each time sx wraps. Both wrap back to 0 after the last pixel,
//   so the counter is already at the origin when the next cell starts.
//   Ports:
//     clock, resetn  clock and async active-low reset
//     enable         advance one pixel
//     clear          force both counters to 0 (frame start)
//     sx_end         sx is on the right-most pixel column of the cell
//     last           current pixel is the final one of the cell
module cell_pixel_counter #(
  parameter int CELL = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic sx_end,
  output logic last
);

  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CW-1:0] MAX_V = CW'(CELL - 1);

  logic [CW-1:0] sx;
  logic [CW-1:0] sy;

  // sx/sy raster within a cell; wrapping on the last pixel keeps the
  // counter aligned to the next cell without an explicit reload.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sx <= '0;
      sy <= '0;
    end else if (clear) begin
      sx <= '0;
      sy <= '0;
    end else if (enable) begin
      if (sx == MAX_V) begin
        sx <= '0;
        sy <= (sy == MAX_V) ? '0 : sy + 1'b1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  assign sx_end = (sx == MAX_V);
  assign last   = sx_end && (sy == MAX_V);

endmodule

// File: rtl/frame_plotter.sv
// frame_plotter
//   Draws the 16x32 game bitmap onto the vga_adapter pixel port, each cell
//   as a CELL x CELL block, redrawing only cells that changed since the last
//   completed frame (or every cell after reset).
//   Ports:
//     clock, resetn  50 MHz clock, async active-low reset
//     display        bitmap, bit 32*col+row
//     frame_start    one-cycle request to draw the current display
//     pix            pixel-write port to vga_adapter (x, y, colour, plot)
//     busy           frame in progress
//     frame_done     one-cycle pulse after the last cell
//     overrun        sticky: frame_start arrived while busy
module frame_plotter
  import frame_plotter_pkg::*;
#(
  parameter int                  CELL      = 3,
  parameter int                  X_OFS     = 56,
  parameter int                  Y_OFS     = 12,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = DEFAULT_FG,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = DEFAULT_BG
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_CELLS-1:0] display,
  input  logic                 frame_start,
  frame_plotter_if.master      pix,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int IDX_W = $clog2(NUM_CELLS);
  localparam int ROW_W = $clog2(GRID_ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  logic [1:0]           state;
  logic [NUM_CELLS-1:0] snap;
  logic [NUM_CELLS-1:0] shown;
  logic [NUM_CELLS-1:0] dirty;
  logic                 force_full;
  logic [IDX_W-1:0]     cell_idx;
  logic [IDX_W-1:0]     nxt_idx;
  logic [8:0]           nxt_x9;
  logic [8:0]           nxt_y9;

  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [COLOUR_W-1:0]  colour_q;
  logic                 plot_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 overrun_q;

  logic                 accept;
  logic                 scan_en;
  logic                 sx_end;
  logic                 last_px;
  logic                 cell_done;

  // The DONE cycle is also the first idle cycle, so a request there is taken.
  assign accept    = frame_start && (state != ST_SCAN);
  // While scanning, plot_q says whether the cell being emitted is dirty.
  assign scan_en   = (state == ST_SCAN) && plot_q;
  assign cell_done = !plot_q || last_px;
  assign nxt_idx   = cell_idx + 1'b1;
  assign nxt_x9    = 9'(X_OFS) + 9'(nxt_idx[IDX_W-1:ROW_W]) * 9'(CELL);
  assign nxt_y9    = 9'(Y_OFS) + 9'(nxt_idx[ROW_W-1:0]) * 9'(CELL);

  cell_pixel_counter #(
    .CELL(CELL)
  ) u_pixel_counter (
    .clock  (clock),
    .resetn (resetn),
    .enable (scan_en),
    .clear  (accept),
    .sx_end (sx_end),
    .last   (last_px)
  );

  // Frame FSM and pixel datapath. The output registers always hold the
  // pixel of the cell currently being emitted, so each edge computes the
  // following pixel: the next one inside a dirty cell, or the origin of
  // the next cell once this cell is finished.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      snap         <= '0;
      shown        <= '0;
      dirty        <= '0;
      force_full   <= 1'b1;
      cell_idx     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= BG_COLOUR;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (frame_start && (state == ST_SCAN)) begin
        overrun_q <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          frame_done_q <= 1'b0;
          if (accept) begin
            snap     <= display;
            dirty    <= force_full ? '1 : (display ^ shown);
            cell_idx <= '0;
            x_q      <= X_W'(9'(X_OFS));
            y_q      <= Y_W'(9'(Y_OFS));
            colour_q <= pick_colour(display[0], FG_COLOUR, BG_COLOUR);
            plot_q   <= force_full | (display[0] ^ shown[0]);
            busy_q   <= 1'b1;
            state    <= ST_SCAN;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          if (cell_done) begin
            if (cell_idx == LAST_IDX) begin
              shown        <= snap;
              force_full   <= 1'b0;
              plot_q       <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              state        <= ST_DONE;
            end else begin
              cell_idx <= nxt_idx;
              x_q      <= nxt_x9[X_W-1:0];
              y_q      <= nxt_y9[Y_W-1:0];
              colour_q <= pick_colour(snap[nxt_idx], FG_COLOUR, BG_COLOUR);
              plot_q   <= dirty[nxt_idx];
            end
          end else if (sx_end) begin
            x_q <= x_q - X_W'(CELL - 1);
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix.x      = x_q;
  assign pix.y      = y_q;
  assign pix.colour = colour_q;
  assign pix.plot   = plot_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/frame_plotter.md
# frame_plotter

Reads the 16x32 game bitmap produced by the game-state logic and drives the `vga_adapter` pixel-write port (`x`, `y`, `colour`, `plot`) in 160x120 mode. Each bitmap cell is drawn as a CELL x CELL block of pixels. Only cells whose value changed since the last drawn frame are redrawn. It sits between the game-state register and the single `vga_adapter` instance, and replaces the free-running x/y scan counters.

## Interface
- `CELL`, 3: pixel edge length of one bitmap cell.
- `X_OFS`, 56: screen x of the left edge of column 0.
- `Y_OFS`, 12: screen y of the top edge of row 0.
- `FG_COLOUR`, 3'b000: colour for a cell bit of 1.
- `BG_COLOUR`, 3'b001: colour for a cell bit of 0.
- `clock` in 1: system clock (50 MHz).
- `resetn` in 1: reset, **asynchronous, active-low**.
- `display` in 512: bitmap; bit 32*col+row, col 0..15 left→right, row 0..31 top→bottom.
- `frame_start` in 1: one-cycle request to draw the current `display`.
- `x` out 8: pixel x to `vga_adapter`.
- `y` out 7: pixel y to `vga_adapter`.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel write strobe, one pixel per high cycle.
- `busy` out 1: high from the accepted `frame_start` until `frame_done`.
- `frame_done` out 1: one-cycle pulse when a frame has been fully drawn.
- `overrun` out 1: sticky; set when `frame_start` arrives while busy.

## Operation
- **State machine:** IDLE → SCAN → DONE → IDLE.
- **IDLE**
  - On `frame_start`, latch `display` into `snap`.
  - Set per-cell dirty = `snap ^ shown`, or all cells dirty if `force_full`.
  - Reset cell index to 0 and go to SCAN.
- **SCAN**
  - Cell index c runs 0..511: col = c[8:5], row = c[4:0] (column-major, rows fastest).
  - Clean cell: consumes exactly 1 cycle with `plot`=0.
  - Dirty cell: consumes CELL² cycles with `plot`=1. Sub-counters sx (fast) and sy each run 0..CELL-1.
  - Pixel address: x = X_OFS + col·CELL + sx; y = Y_OFS + row·CELL + sy.
  - Pixel colour: FG_COLOUR if `snap` bit is 1, else BG_COLOUR.
  - Address arithmetic is done in 9 bits, then truncated; the parameters must keep x ≤ 159 and y ≤ 119.
  - After the final cycle of cell 511, go to DONE.
- **DONE**
  - `shown` ← `snap`; clear `force_full`; pulse `frame_done`; return to IDLE.
- `display` changes after acceptance are ignored; drawing uses `snap` only.
- `frame_start` while `busy` is dropped and sets `overrun`, which stays set until reset.
- **Reset values:** `x`=0, `y`=0, `colour`=BG_COLOUR, `plot`=0, `busy`=0, `frame_done`=0, `overrun`=0, state IDLE, `shown`=0, `force_full`=1.
- Reset asserted mid-scan returns everything to reset values immediately, and the next frame is a full redraw.

## Timing
- All outputs are registered.
- `frame_start` sampled high at edge 0:
  - `busy`=1 from cycle 1.
  - The first cell's output appears in cycle 1.
- Frame length = (number of clean cells) + CELL²·(number of dirty cells) cycles, occupying cycles 1..N.
- `frame_done`=1 in cycle N+1 only, and `busy` falls in that same cycle.
- The FSM is in IDLE during the `frame_done` cycle, so a `frame_start` in that cycle is accepted.
- Full redraw (CELL=3): 4608 plot cycles, `frame_done` in cycle 4609.
- Fully clean frame: 512 cycles, `frame_done` in cycle 513.
- Throughput: at most one pixel per clock; `vga_adapter` accepts every cycle, so no back-pressure.

## Structure
- **Shared package:**
  - GRID_COLS=16, GRID_ROWS=32.
  - State encoding (IDLE/SCAN/DONE).
  - Default FG/BG colour constants, used by the datapath colour logic as well.
- **One sub-module, `cell_pixel_counter`:**
  - Holds the sx/sy counters with `clock`, `resetn`, `enable`.
  - Outputs `last` when sx=sy=CELL-1.
  - The cell-index advance is driven from `last`.
- `snap`, `shown` and the dirty logic stay in `frame_plotter`.

## Test plan
- **Full redraw after reset:** reset, all-zero `display`, pulse `frame_start`.
  - Expect 4608 plots, all colour 001.
  - First plot (56,12); last plot (103,107).
  - `frame_done` in cycle 4609.
- **Unchanged frame:** repeat `frame_start` with the same `display`.
  - Expect zero plots and `frame_done` in cycle 513.
- **Single changed cell:** set bit 32·5+31.
  - Expect exactly 9 plots, colour 000, at x 71..73, y 105..107.
  - `frame_done` in cycle 521.
- **Request while busy:** a second `frame_start` during a scan.
  - Scan output is unchanged and `overrun`=1 until reset.
- **Display change mid-scan:** invert `display` 100 cycles into a full redraw.
  - All plotted colours match the value latched at `frame_start`.
- **Reset mid-scan:** deassert `resetn` during cell 200.
  - `plot`, `busy` and `overrun` are 0 with no clock edge.
  - The next frame is a full 4608-plot redraw.
